tcp_stream_encoder: RTL

//  Parametrised streaming TCP segment builder for the UDP/TCP TX path. Latches header fields and
//  pre-encoded option words on start, then emits header, options and payload as a valid/ready

---
 rtl/tcp_pkg.sv | 47 ++++
 rtl/ones_comp_acc32.sv | 36 +++
 rtl/tcp_stream_encoder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_pkg.sv
// Shared TCP/UDP TX definitions: FSM encoding, header word offsets, flag
// bit positions, protocol number and a one's-complement add helper.
package tcp_pkg;

  // Segment builder FSM encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_OPT  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_LAST = 3'd4;  // final word loaded, waiting for its handshake
  localparam logic [2:0] ST_DONE = 3'd5;

  // 32-bit word offsets inside the fixed 20-byte TCP header
  localparam logic [3:0] HDR_PORTS = 4'd0;
  localparam logic [3:0] HDR_SEQ   = 4'd1;
  localparam logic [3:0] HDR_ACK   = 4'd2;
  localparam logic [3:0] HDR_CTRL  = 4'd3;
  localparam logic [3:0] HDR_URG   = 4'd4;

  // Bit positions inside the 6-bit flags field
  localparam int FLAG_FIN = 0;
  localparam int FLAG_SYN = 1;
  localparam int FLAG_RST = 2;
  localparam int FLAG_PSH = 3;
  localparam int FLAG_ACK = 4;
  localparam int FLAG_URG = 5;

  localparam logic [7:0] PROTO_TCP = 8'd6;

  // Header fields latched on start
  typedef struct packed {
    logic [31:0] ports;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [5:0]  flags;
    logic [15:0] window;
    logic [15:0] urg_ptr;
  } tcp_hdr_t;

  // 32-bit one's-complement add; end-around carry cannot overflow again
  function automatic logic [31:0] oc_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[31:0] + {31'd0, s[32]};
  endfunction

endpackage

// File: rtl/ones_comp_acc32.sv
// 32-bit one's-complement accumulator with end-around carry and a 16-bit
// fold output. Shared between the TCP and UDP encoders.
module ones_comp_acc32
  import tcp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        add,
  input  logic [31:0] add_val,
  output logic [15:0] fold
);

  logic [31:0] acc_q, acc_d;
  logic [16:0] fold_s;

  // Next accumulator value: clear wins over load, load over add
  always_comb begin
    acc_d = acc_q;
    if (clear)     acc_d = 32'd0;
    else if (load) acc_d = load_val;
    else if (add)  acc_d = oc_add32(acc_q, add_val);
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) acc_q <= 32'd0;
    else       acc_q <= acc_d;
  end

  assign fold_s = {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]};
  assign fold   = fold_s[15:0] + {15'd0, fold_s[16]};

endmodule

// File: rtl/tcp_stream_encoder.sv
// Streaming TCP segment builder: header, options and payload as a
// valid/ready word stream, checksum reported after the last word.
module tcp_stream_encoder
  import tcp_pkg::*;
#(
  parameter int         MAX_OPT_WORDS = 10,
  parameter logic [7:0] PROTO         = PROTO_TCP
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               src_ip,
  input  logic [31:0]               dest_ip,
  input  logic [31:0]               hdr_ports,
  input  logic [31:0]               seq_num,
  input  logic [31:0]               ack_num,
  input  logic [5:0]                flags,
  input  logic [15:0]               window,
  input  logic [15:0]               urg_ptr,
  input  logic [3:0]                opt_words,
  input  logic [32*MAX_OPT_WORDS-1:0] opt_data,
  input  logic [15:0]               pay_len,
  input  logic [31:0]               s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [31:0]               m_data,
  output logic [3:0]                m_keep,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [15:0]               seg_len,
  output logic [15:0]               csum,
  output logic                      csum_valid,
  output logic                      busy
);

  logic [2:0]  state_q, state_d;
  tcp_hdr_t    hdr_q, hdr_d;
  logic [MAX_OPT_WORDS-1:0][31:0] opt_q, opt_d;
  logic [3:0]  nopt_q, nopt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] rem_q, rem_d;        // payload bytes still to send
  logic [15:0] seg_len_q, seg_len_d;
  logic [31:0] m_data_q, m_data_d;
  logic [3:0]  m_keep_q, m_keep_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic [15:0] csum_q, csum_d;
  logic        csum_valid_q, csum_valid_d;

  logic [3:0]  nopt_in;
  logic [15:0] seg_len_in;
  logic [31:0] acc_load_val, acc_add_val;
  logic        acc_clear, acc_load, acc_add;
  logic [15:0] acc_fold;
  logic        out_en, s_ready_c;
  logic [31:0] hdr_word, opt_word, data_masked;
  logic [3:0]  data_keep;
  logic        emit, emit_last;
  logic [31:0] emit_word;
  logic [3:0]  emit_keep;

  assign nopt_in    = (opt_words > 4'(MAX_OPT_WORDS)) ? 4'(MAX_OPT_WORDS) : opt_words;
  assign seg_len_in = {10'd0, (4'd5 + nopt_in), 2'b00} + pay_len;
  // Pseudo-header sum plus the first header word, which leaves on the start edge
  assign acc_load_val = oc_add32(oc_add32(oc_add32(src_ip, dest_ip),
                                          {8'd0, PROTO, seg_len_in}), hdr_ports);

  assign out_en    = !m_valid_q || m_ready;
  assign s_ready_c = !reset && (state_q == ST_DATA) && out_en;

  // Header word selected by the running word index
  always_comb begin
    case (idx_q)
      HDR_SEQ:  hdr_word = hdr_q.seq;
      HDR_ACK:  hdr_word = hdr_q.ack;
      HDR_CTRL: hdr_word = {4'd5 + nopt_q, 6'b0, hdr_q.flags, hdr_q.window};
      HDR_URG:  hdr_word = {16'h0000, hdr_q.urg_ptr};
      default:  hdr_word = hdr_q.ports;
    endcase
  end

  // Option word mux
  always_comb begin
    opt_word = 32'd0;
    for (int i = 0; i < MAX_OPT_WORDS; i++)
      if (idx_q == 4'(i)) opt_word = opt_q[i];
  end

  // Payload keep mask (MSB-aligned on the final word) and zeroing of unused bytes
  always_comb begin
    data_keep = 4'b1111;
    if (rem_q <= 16'd4) begin
      case (rem_q[2:0])
        3'd1:    data_keep = 4'b1000;
        3'd2:    data_keep = 4'b1100;
        3'd3:    data_keep = 4'b1110;
        default: data_keep = 4'b1111;
      endcase
    end
    data_masked = s_data & {{8{data_keep[3]}}, {8{data_keep[2]}},
                            {8{data_keep[1]}}, {8{data_keep[0]}}};
  end

  // FSM, field latching, output register and checksum sequencing
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    opt_d        = opt_q;
    nopt_d       = nopt_q;
    idx_d        = idx_q;
    rem_d        = rem_q;
    seg_len_d    = seg_len_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    csum_d       = csum_q;
    csum_valid_d = 1'b0;
    acc_clear    = 1'b0;
    acc_load     = 1'b0;
    emit         = 1'b0;
    emit_last    = 1'b0;
    emit_word    = 32'd0;
    emit_keep    = 4'b1111;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: if (start) begin
        hdr_d.ports   = hdr_ports;
        hdr_d.seq     = seq_num;
        hdr_d.ack     = ack_num;
        hdr_d.flags   = flags;
        hdr_d.window  = window;
        hdr_d.urg_ptr = urg_ptr;
        opt_d         = opt_data;
        nopt_d        = nopt_in;
        rem_d         = pay_len;
        seg_len_d     = seg_len_in;
        m_data_d      = hdr_ports;
        m_keep_d      = 4'b1111;
        m_valid_d     = 1'b1;
        m_last_d      = 1'b0;
        acc_load      = 1'b1;
        idx_d         = HDR_SEQ;
        state_d       = ST_HDR;
      end
      ST_HDR: if (out_en) begin
        emit      = 1'b1;
        emit_word = hdr_word;
        idx_d     = idx_q + 4'd1;
        if (idx_q == HDR_URG) begin
          idx_d = 4'd0;
          if (nopt_q != 4'd0)     state_d = ST_OPT;
          else if (rem_q != 16'd0) state_d = ST_DATA;
          else begin
            state_d   = ST_LAST;
            emit_last = 1'b1;
          end
        end
      end
      ST_OPT: if (out_en) begin
        emit      = 1'b1;
        emit_word = opt_word;
        idx_d     = idx_q + 4'd1;
        if (idx_q == nopt_q - 4'd1) begin
          idx_d = 4'd0;
          if (rem_q != 16'd0) state_d = ST_DATA;
          else begin
            state_d   = ST_LAST;
            emit_last = 1'b1;
          end
        end
      end
      ST_DATA: if (s_valid && s_ready_c) begin
        emit      = 1'b1;
        emit_word = data_masked;
        emit_keep = data_keep;
        if (rem_q <= 16'd4) begin
          rem_d     = 16'd0;
          emit_last = 1'b1;
          state_d   = ST_LAST;
        end else begin
          rem_d = rem_q - 16'd4;
        end
      end
      ST_LAST: if (m_valid_q && m_ready && m_last_q) begin
        // Last word already added at load time, so the sum is final here
        csum_d       = ~acc_fold;
        csum_valid_d = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        acc_clear = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      m_data_d  = emit_word;
      m_keep_d  = emit_keep;
      m_valid_d = 1'b1;
      m_last_d  = emit_last;
    end
  end

  assign acc_add     = emit;
  assign acc_add_val = emit_word;

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hdr_q        <= '0;
      opt_q        <= '0;
      nopt_q       <= 4'd0;
      idx_q        <= 4'd0;
      rem_q        <= 16'd0;
      seg_len_q    <= 16'd0;
      m_data_q     <= 32'd0;
      m_keep_q     <= 4'd0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      csum_q       <= 16'd0;
      csum_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      opt_q        <= opt_d;
      nopt_q       <= nopt_d;
      idx_q        <= idx_d;
      rem_q        <= rem_d;
      seg_len_q    <= seg_len_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      csum_q       <= csum_d;
      csum_valid_q <= csum_valid_d;
    end
  end

  ones_comp_acc32 u_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (acc_clear),
    .load     (acc_load),
    .load_val (acc_load_val),
    .add      (acc_add),
    .add_val  (acc_add_val),
    .fold     (acc_fold)
  );

  assign s_ready    = s_ready_c;
  assign m_data     = m_data_q;
  assign m_keep     = m_keep_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign seg_len    = seg_len_q;
  assign csum       = csum_q;
  assign csum_valid = csum_valid_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
